// File: rtl/count_ext_capture.sv
// Upper extension of a cascaded binary counter with compare match,
// overflow flag and a snapshot register read over valid/ready.
module count_ext_capture #(
  parameter int LOW_W  = 4,
  parameter int HIGH_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    carry_in,
  input  logic [LOW_W-1:0]        low_val,
  input  logic                    load,
  input  logic [LOW_W+HIGH_W-1:0] load_val,
  input  logic                    cap_req,
  input  logic                    rd_ready,
  input  logic                    ovf_clr,
  input  logic [LOW_W+HIGH_W-1:0] match_val,
  output logic [HIGH_W-1:0]       high_val,
  output logic                    c_out,
  output logic [LOW_W+HIGH_W-1:0] cap_data,
  output logic                    cap_valid,
  output logic                    cap_miss,
  output logic                    ovf,
  output logic                    match
);

  logic                    all_ones;
  logic                    wrap;
  logic                    hs;
  logic                    take;
  logic                    drop;
  logic [LOW_W+HIGH_W-1:0] full_val;

  assign all_ones = &high_val;
  assign c_out    = carry_in & all_ones;
  assign wrap     = !load & c_out;
  assign full_val = {high_val, low_val};

  assign hs   = cap_valid & rd_ready;
  assign take = cap_req & (!cap_valid | hs);
  assign drop = cap_req & cap_valid & !rd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_val <= '0;
    end else if (load) begin
      high_val <= load_val[LOW_W+HIGH_W-1:LOW_W];
    end else if (carry_in) begin
      high_val <= high_val + 1'b1;
    end
  end

  // Wrap beats a simultaneous clear so an overflow is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (wrap) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else if (take) begin
      cap_data  <= full_val;
      cap_valid <= 1'b1;
    end else if (hs) begin
      cap_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_miss <= 1'b0;
    end else if (drop) begin
      cap_miss <= 1'b1;
    end else if (hs) begin
      cap_miss <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match <= 1'b0;
    end else begin
      match <= (full_val == match_val) & !load;
    end
  end

endmodule

// File: tb/tb_count_ext_capture.sv
// Randomized scoreboard bench for count_ext_capture; the bench
// itself acts as the low nibble stage of a 16-bit counter.
module tb_count_ext_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        carry_in;
  logic [3:0]  low_val;
  logic        load;
  logic [15:0] load_val;
  logic        cap_req;
  logic        rd_ready;
  logic        ovf_clr;
  logic [15:0] match_val;
  logic [11:0] high_val;
  logic        c_out;
  logic [15:0] cap_data;
  logic        cap_valid;
  logic        cap_miss;
  logic        ovf;
  logic        match;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  logic [15:0] m_cnt;
  bit          m_ovf;
  bit          m_vld;
  bit          m_miss;
  bit          m_match;

  bit          held;
  logic [15:0] pdata;

  always #5 clk = ~clk;

  count_ext_capture #(.LOW_W(4), .HIGH_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .carry_in  (carry_in),
    .low_val   (low_val),
    .load      (load),
    .load_val  (load_val),
    .cap_req   (cap_req),
    .rd_ready  (rd_ready),
    .ovf_clr   (ovf_clr),
    .match_val (match_val),
    .high_val  (high_val),
    .c_out     (c_out),
    .cap_data  (cap_data),
    .cap_valid (cap_valid),
    .cap_miss  (cap_miss),
    .ovf       (ovf),
    .match     (match)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt   = '0;
    m_ovf   = 0;
    m_vld   = 0;
    m_miss  = 0;
    m_match = 0;
    q.delete();
  endtask

  task automatic idle_inputs();
    carry_in  = 0;
    low_val   = '0;
    load      = 0;
    load_val  = '0;
    cap_req   = 0;
    rd_ready  = 0;
    ovf_clr   = 0;
    match_val = 16'hFFFF;
  endtask

  task automatic step(input bit ld, input logic [15:0] lv,
                      input bit en, input bit req, input bit rdy,
                      input bit clr, input logic [15:0] mv);
    bit hs, take, drop, ci;
    @(negedge clk);
    chk("high_val", high_val, m_cnt[15:4]);
    chk("ovf", ovf, m_ovf);
    chk("match", match, m_match);
    chk("cap_valid", cap_valid, m_vld);
    chk("cap_miss", cap_miss, m_miss);
    ci        = en && (m_cnt[3:0] == 4'hF);
    load      = ld;
    load_val  = lv;
    carry_in  = ci;
    low_val   = m_cnt[3:0];
    cap_req   = req;
    rd_ready  = rdy;
    ovf_clr   = clr;
    match_val = mv;
    #1;
    chk("c_out", c_out, ci && (m_cnt[15:4] == 12'hFFF));
    hs   = m_vld && rdy;
    take = req && (!m_vld || hs);
    drop = req && m_vld && !rdy;
    if (take) q.push_back(m_cnt);
    m_vld   = take ? 1'b1 : (hs ? 1'b0 : m_vld);
    m_miss  = drop ? 1'b1 : (hs ? 1'b0 : m_miss);
    m_match = (m_cnt == mv) && !ld;
    if (!ld && en && m_cnt == 16'hFFFF) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (ld) m_cnt = lv;
    else if (en) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high_val"}, high_val, 0);
    chk({tag, "_cap_data"}, cap_data, 0);
    chk({tag, "_cap_valid"}, cap_valid, 0);
    chk({tag, "_cap_miss"}, cap_miss, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_c_out"}, c_out, 0);
  endtask

  // Monitor: pops the scoreboard on every handshake.
  initial begin
    held = 0;
    pdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        held = 0;
      end else begin
        if (held && cap_valid) chk("cap_stable", cap_data, pdata);
        if (cap_valid && rd_ready) begin
          if (q.size() == 0) chk("cap_unexpected", 1, 0);
          else chk("cap_data", cap_data, q.pop_front());
        end
        held  = cap_valid && !rd_ready;
        pdata = cap_data;
      end
    end
  end

  initial begin
    logic [15:0] lv;
    logic [15:0] mv;
    reset = 0;
    idle_inputs();
    model_clear();
    #2;
    chk_all_zero("por");
    repeat (2) @(negedge clk);
    reset = 1;

    // Load beats carry.
    step(1, 16'h000F, 0, 0, 0, 0, 16'hFFFF);
    step(1, 16'h1230, 1, 0, 0, 0, 16'hFFFF);
    // Wrap, then wrap with clear in same cycle.
    step(1, 16'hFFFF, 0, 0, 0, 0, 16'hFFFF);
    step(0, 16'h0000, 1, 0, 0, 0, 16'hFFFF);
    step(0, 16'h0000, 0, 0, 0, 0, 16'hFFFF);
    step(1, 16'hFFFF, 0, 0, 0, 1, 16'hFFFF);
    step(0, 16'h0000, 1, 0, 0, 1, 16'hFFFF);
    step(0, 16'h0000, 0, 0, 0, 0, 16'hFFFF);
    // Coherent capture across the nibble carry.
    step(1, 16'h0FFF, 0, 0, 0, 1, 16'hFFFF);
    step(0, 16'h0000, 1, 1, 0, 0, 16'hFFFF);
    // Backpressure: drop, then accept with new request.
    step(0, 16'h0000, 1, 1, 0, 0, 16'hFFFF);
    step(0, 16'h0000, 1, 1, 1, 0, 16'hFFFF);
    step(0, 16'h0000, 1, 0, 1, 0, 16'hFFFF);
    step(0, 16'h0000, 0, 0, 0, 0, 16'hFFFF);
    // Match while counting, hold re-assert, and suppression on load.
    step(1, 16'h0100, 0, 0, 0, 0, 16'h0105);
    repeat (8) step(0, 16'h0000, 1, 0, 0, 0, 16'h0105);
    step(1, 16'h0105, 0, 0, 0, 0, 16'h0105);
    repeat (3) step(0, 16'h0000, 0, 0, 0, 0, 16'h0105);
    step(1, 16'h0105, 0, 0, 0, 0, 16'h0105);
    step(0, 16'h0000, 0, 0, 0, 0, 16'h0105);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0: lv = 16'hFFF0 | 16'($urandom_range(0, 15));
        1: lv = 16'h0100;
        2: lv = 16'h0FF0 | 16'($urandom_range(0, 15));
        3: lv = 16'h3A50;
        default: lv = 16'($urandom);
      endcase
      mv = ($urandom_range(0, 1) == 1) ? 16'h0105
           : m_cnt + 16'($urandom_range(0, 3));
      step($urandom_range(0, 15) == 0, lv,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, mv);
    end
    step(0, 16'h0000, 0, 0, 0, 0, 16'hFFFF);
    chk("sb_level", q.size(), m_vld);

    // Async reset with a pending snapshot.
    step(1, 16'h3A50, 0, 0, 0, 0, 16'hFFFF);
    step(0, 16'h0000, 0, 1, 0, 0, 16'hFFFF);
    @(negedge clk);
    idle_inputs();
    chk("pre_rst_high", high_val, 12'h3A5);
    chk("pre_rst_valid", cap_valid, 1);
    #3;
    reset = 0;
    #1;
    chk_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    chk_all_zero("held_rst");
    reset = 1;
    step(0, 16'h0000, 0, 0, 1, 0, 16'hFFFF);
    step(0, 16'h0000, 0, 0, 0, 0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
